// File: rtl/nubus_host_master_if.sv
// Host request port plus split NuBus pins (_i/_o/_oe, active-low values) for nubus_host_master.
// The master modport is the initiator's view; slave is the view of whatever sits across from it.
interface nubus_host_master_if;
    logic        host_valid;
    logic        host_write;
    logic [31:0] host_addr;
    logic [31:0] host_wdata;
    logic        host_ready;
    logic [31:0] host_rdata;
    logic [1:0]  host_status;

    logic [31:0] nub_adn_i;
    logic [31:0] nub_adn_o;
    logic        nub_adn_oe;
    logic        nub_startn_i;
    logic        nub_startn_o;
    logic        nub_startn_oe;
    logic        nub_ackn_i;
    logic        nub_rqstn_i;
    logic        nub_rqstn_o;
    logic        nub_rqstn_oe;
    logic        nub_tm1n_i;
    logic        nub_tm1n_o;
    logic        nub_tm0n_i;
    logic        nub_tm0n_o;
    logic        nub_tmoe;
    logic [3:0]  nub_arbn_i;
    logic [3:0]  nub_arbn_o;
    logic        nub_spn_o;
    logic        nub_spvn_o;
    logic        nub_spoe;

    modport master (
        input  host_valid, host_write, host_addr, host_wdata,
        output host_ready, host_rdata, host_status,
        input  nub_adn_i, nub_startn_i, nub_ackn_i, nub_rqstn_i,
        input  nub_tm1n_i, nub_tm0n_i, nub_arbn_i,
        output nub_adn_o, nub_adn_oe, nub_startn_o, nub_startn_oe,
        output nub_rqstn_o, nub_rqstn_oe, nub_tm1n_o, nub_tm0n_o, nub_tmoe,
        output nub_arbn_o, nub_spn_o, nub_spvn_o, nub_spoe
    );

    modport slave (
        output host_valid, host_write, host_addr, host_wdata,
        input  host_ready, host_rdata, host_status,
        output nub_adn_i, nub_startn_i, nub_ackn_i, nub_rqstn_i,
        output nub_tm1n_i, nub_tm0n_i, nub_arbn_i,
        input  nub_adn_o, nub_adn_oe, nub_startn_o, nub_startn_oe,
        input  nub_rqstn_o, nub_rqstn_oe, nub_tm1n_o, nub_tm0n_o, nub_tmoe,
        input  nub_arbn_o, nub_spn_o, nub_spvn_o, nub_spoe
    );
endinterface

// File: rtl/nubus_host_master.sv
// Motherboard-side NuBus initiator: runs one single-word read or write per host request
// through arbitration, address cycle, ack wait and status capture.
module nubus_host_master #(
    parameter logic [3:0] ARB_ID         = 4'hF,
    parameter int         WDT_W          = 8,
    parameter bit         NON_ECC_PARITY = 1'b1
) (
    input  logic                  nub_clk,
    input  logic                  nub_reset,
    nubus_host_master_if.master   bus
);
    typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, DONE} state_t;

    localparam logic [WDT_W-1:0] WDT_LAST = {{(WDT_W-1){1'b1}}, 1'b0};
    localparam logic [WDT_W-1:0] WDT_ONE  = {{(WDT_W-1){1'b0}}, 1'b1};
    localparam logic             SPVN_DRV = !NON_ECC_PARITY;

    state_t            state;
    logic              match;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic [WDT_W-1:0]  wdt;
    logic [3:0]        arb_drive;
    logic              higher_ok;
    logic              unused_rqstn;

    assign unused_rqstn = bus.nub_rqstn_i;

    function automatic logic sp_of(input logic [31:0] ad);
        return NON_ECC_PARITY ? ~^ad : 1'b1;
    endfunction

    // Arbitration contest: drive our ID bit only while no higher-priority bit we lack is asserted.
    always_comb begin
        arb_drive = 4'hF;
        higher_ok = 1'b1;
        if (state == ARB) begin
            for (int i = 0; i < 4; i++) begin
                higher_ok = 1'b1;
                for (int j = i + 1; j < 4; j++) begin
                    higher_ok = higher_ok & (ARB_ID[j] | bus.nub_arbn_i[j]);
                end
                arb_drive[i] = ~(ARB_ID[i] & higher_ok);
            end
        end else begin
            arb_drive = 4'hF;
        end
    end

    assign bus.nub_arbn_o = arb_drive;

    // Transaction sequencer with all bus and host outputs registered.
    always_ff @(posedge nub_clk or posedge nub_reset) begin
        if (nub_reset) begin
            state             <= IDLE;
            match             <= 1'b0;
            addr_q            <= 32'h0000_0000;
            wdata_q           <= 32'h0000_0000;
            write_q           <= 1'b0;
            wdt               <= '0;
            bus.host_ready    <= 1'b0;
            bus.host_rdata    <= 32'h0000_0000;
            bus.host_status   <= 2'd0;
            bus.nub_adn_o     <= 32'hFFFF_FFFF;
            bus.nub_adn_oe    <= 1'b0;
            bus.nub_startn_o  <= 1'b1;
            bus.nub_startn_oe <= 1'b0;
            bus.nub_rqstn_o   <= 1'b1;
            bus.nub_rqstn_oe  <= 1'b0;
            bus.nub_tm1n_o    <= 1'b1;
            bus.nub_tm0n_o    <= 1'b1;
            bus.nub_tmoe      <= 1'b0;
            bus.nub_spn_o     <= 1'b1;
            bus.nub_spvn_o    <= 1'b1;
            bus.nub_spoe      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.host_valid) begin
                        addr_q           <= bus.host_addr;
                        wdata_q          <= bus.host_wdata;
                        write_q          <= bus.host_write;
                        match            <= 1'b0;
                        bus.nub_rqstn_o  <= 1'b0;
                        bus.nub_rqstn_oe <= 1'b1;
                        state            <= ARB;
                    end
                end
                ARB: begin
                    // Grant needs two consecutive winning samples; the second also needs an idle bus.
                    if (~bus.nub_arbn_i == ARB_ID) begin
                        if (match && bus.nub_startn_i && bus.nub_ackn_i) begin
                            match             <= 1'b0;
                            bus.nub_rqstn_o   <= 1'b1;
                            bus.nub_rqstn_oe  <= 1'b0;
                            bus.nub_startn_o  <= 1'b0;
                            bus.nub_startn_oe <= 1'b1;
                            bus.nub_adn_o     <= ~addr_q;
                            bus.nub_adn_oe    <= 1'b1;
                            bus.nub_spn_o     <= sp_of(~addr_q);
                            bus.nub_spvn_o    <= SPVN_DRV;
                            bus.nub_spoe      <= NON_ECC_PARITY;
                            bus.nub_tm1n_o    <= ~write_q;
                            bus.nub_tm0n_o    <= 1'b1;
                            bus.nub_tmoe      <= 1'b1;
                            state             <= ADDR;
                        end else begin
                            match <= 1'b1;
                        end
                    end else begin
                        match <= 1'b0;
                    end
                end
                ADDR: begin
                    wdt               <= '0;
                    bus.nub_startn_o  <= 1'b1;
                    bus.nub_startn_oe <= 1'b0;
                    bus.nub_tm1n_o    <= 1'b1;
                    bus.nub_tm0n_o    <= 1'b1;
                    bus.nub_tmoe      <= 1'b0;
                    if (write_q) begin
                        bus.nub_adn_o  <= ~wdata_q;
                        bus.nub_adn_oe <= 1'b1;
                        bus.nub_spn_o  <= sp_of(~wdata_q);
                        bus.nub_spvn_o <= SPVN_DRV;
                        bus.nub_spoe   <= NON_ECC_PARITY;
                    end else begin
                        bus.nub_adn_o  <= 32'hFFFF_FFFF;
                        bus.nub_adn_oe <= 1'b0;
                        bus.nub_spn_o  <= 1'b1;
                        bus.nub_spvn_o <= 1'b1;
                        bus.nub_spoe   <= 1'b0;
                    end
                    state <= DATA;
                end
                DATA: begin
                    // Ack is checked before the watchdog so a same-edge ack still reports its status.
                    if (!bus.nub_ackn_i || (wdt == WDT_LAST)) begin
                        if (!bus.nub_ackn_i) begin
                            if (!write_q) begin
                                bus.host_rdata <= ~bus.nub_adn_i;
                            end
                            bus.host_status <= {bus.nub_tm1n_i, bus.nub_tm0n_i};
                        end else begin
                            bus.host_status <= 2'd2;
                        end
                        bus.host_ready <= 1'b1;
                        bus.nub_adn_o  <= 32'hFFFF_FFFF;
                        bus.nub_adn_oe <= 1'b0;
                        bus.nub_spn_o  <= 1'b1;
                        bus.nub_spvn_o <= 1'b1;
                        bus.nub_spoe   <= 1'b0;
                        state          <= DONE;
                    end else begin
                        wdt <= wdt + WDT_ONE;
                    end
                end
                DONE: begin
                    bus.host_ready <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nubus_host_master.sv
// Self-checking bench for nubus_host_master: directed vector table, hand sequences for
// arbitration loss / DONE / mid-transfer reset, and randomized transfers against a reference model.
module tb_nubus_host_master;
    localparam logic [3:0] ID = 4'h7;
    localparam int         WW = 4;
    localparam int         DATA_MAX = (1 << WW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] comp_arb;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [31:0] prev_rd;

    always #5 clk = ~clk;

    nubus_host_master_if bus();

    // Wired-AND arbitration lines with a small settling delay.
    assign #1 bus.nub_arbn_i = bus.nub_arbn_o & comp_arb;

    nubus_host_master #(.ARB_ID(ID), .WDT_W(WW), .NON_ECC_PARITY(1'b1)) dut (
        .nub_clk   (clk),
        .nub_reset (rst),
        .bus       (bus)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        int          waits;
        logic [1:0]  code;
        int          hold;
        logic [1:0]  exp_st;
        int          exp_lat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_released(input string tag);
        chk({tag, "_adn_oe"},    {31'd0, bus.nub_adn_oe},    32'd0);
        chk({tag, "_startn_oe"}, {31'd0, bus.nub_startn_oe}, 32'd0);
        chk({tag, "_rqstn_oe"},  {31'd0, bus.nub_rqstn_oe},  32'd0);
        chk({tag, "_tmoe"},      {31'd0, bus.nub_tmoe},      32'd0);
        chk({tag, "_spoe"},      {31'd0, bus.nub_spoe},      32'd0);
        chk({tag, "_arbn_o"},    {28'd0, bus.nub_arbn_o},    32'hF);
    endtask

    task automatic run_txn(input vec_t v, input bit poke_done);
        int  n;
        int  a;
        int  a_exp;
        bit  addr_seen;
        bit  done;
        a_exp = (v.hold <= 1) ? 3 : v.hold + 2;
        @(negedge clk);
        comp_arb       = (v.hold > 0) ? 4'h1 : 4'hF;
        bus.host_write = v.wr;
        bus.host_addr  = v.addr;
        bus.host_wdata = v.wdata;
        bus.host_valid = 1'b1;
        n = 0; a = 0; addr_seen = 1'b0; done = 1'b0;
        while (!done && n < 80) begin
            @(negedge clk);
            n++;
            bus.host_valid = 1'b0;
            if (bus.host_ready) begin
                done = 1'b1;
            end else begin
                if (!addr_seen && bus.nub_startn_oe && !bus.nub_startn_o) begin
                    addr_seen = 1'b1;
                    a = n;
                    chk("addr_cycle",   a, a_exp);
                    chk("addr_adn",     bus.nub_adn_o, ~v.addr);
                    chk("addr_adn_oe",  {31'd0, bus.nub_adn_oe}, 32'd1);
                    chk("addr_tm1n",    {31'd0, bus.nub_tm1n_o}, {31'd0, ~v.wr});
                    chk("addr_tm0n",    {31'd0, bus.nub_tm0n_o}, 32'd1);
                    chk("addr_tmoe",    {31'd0, bus.nub_tmoe}, 32'd1);
                    chk("addr_rqst_rel", {31'd0, bus.nub_rqstn_oe}, 32'd0);
                    chk("addr_arb_rel", {28'd0, bus.nub_arbn_o}, 32'hF);
                    chk("addr_spn",     {31'd0, bus.nub_spn_o}, {31'd0, ~^(~v.addr)});
                    chk("addr_spoe",    {31'd0, bus.nub_spoe}, 32'd1);
                end else if (!addr_seen) begin
                    chk("arb_rqstn",    {30'd0, bus.nub_rqstn_oe, bus.nub_rqstn_o}, 32'd2);
                    chk("arb_no_start", {31'd0, bus.nub_startn_oe}, 32'd0);
                    chk("arb_arbn_o",   {28'd0, bus.nub_arbn_o},
                        (v.hold > 0 && n <= v.hold) ? 32'hF : {28'd0, ~ID});
                end else begin
                    chk("data_start_rel", {31'd0, bus.nub_startn_oe}, 32'd0);
                    chk("data_tm_rel",    {31'd0, bus.nub_tmoe}, 32'd0);
                    chk("data_adn_oe",    {31'd0, bus.nub_adn_oe}, {31'd0, v.wr});
                    if (v.wr) begin
                        chk("data_wdata", bus.nub_adn_o, ~v.wdata);
                        chk("data_spn",   {31'd0, bus.nub_spn_o}, {31'd0, ~^(~v.wdata)});
                        chk("data_spvn",  {31'd0, bus.nub_spvn_o}, 32'd0);
                    end
                end
                if (v.hold > 0 && n == v.hold) comp_arb = 4'hF;
                if (addr_seen && v.waits < DATA_MAX && n == a + 1 + v.waits) begin
                    bus.nub_ackn_i = 1'b0;
                    bus.nub_adn_i  = ~v.resp;
                    bus.nub_tm1n_i = v.code[1];
                    bus.nub_tm0n_i = v.code[0];
                end else begin
                    bus.nub_ackn_i = 1'b1;
                    bus.nub_adn_i  = 32'hFFFF_FFFF;
                    bus.nub_tm1n_i = 1'b1;
                    bus.nub_tm0n_i = 1'b1;
                end
            end
        end
        bus.nub_ackn_i = 1'b1;
        bus.nub_adn_i  = 32'hFFFF_FFFF;
        bus.nub_tm1n_i = 1'b1;
        bus.nub_tm0n_i = 1'b1;
        comp_arb       = 4'hF;
        chk("ready_seen", {31'd0, done}, 32'd1);
        chk("latency",    n, v.exp_lat);
        chk("status",     {30'd0, bus.host_status}, {30'd0, v.exp_st});
        chk("rdata",      bus.host_rdata, v.exp_rd);
        chk_released("done");
        if (poke_done) begin
            bus.host_valid = 1'b1;
            bus.host_write = 1'b0;
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        chk("ready_pulse", {31'd0, bus.host_ready}, 32'd0);
        chk("rdata_held",  bus.host_rdata, v.exp_rd);
        if (poke_done) begin
            repeat (3) begin
                @(negedge clk);
                chk("done_valid_ignored", {31'd0, bus.nub_rqstn_oe}, 32'd0);
            end
        end
    endtask

    initial begin
        vec_t r;
        bit   acked;
        int   dc;

        vt[0] = '{1'b0, 32'hF900_0010, 32'h0,          32'hDEAD_BEEF, 0,  2'd0, 0, 2'd0, 5,  32'hDEAD_BEEF};
        vt[1] = '{1'b1, 32'hF900_0020, 32'h1234_5678,  32'h0BAD_0BAD, 3,  2'd0, 0, 2'd0, 8,  32'hDEAD_BEEF};
        vt[2] = '{1'b0, 32'hF900_0030, 32'h0,          32'h1111_2222, 1,  2'd1, 0, 2'd1, 6,  32'h1111_2222};
        vt[3] = '{1'b0, 32'hF900_0040, 32'h0,          32'h3333_4444, 2,  2'd3, 0, 2'd3, 7,  32'h3333_4444};
        vt[4] = '{1'b0, 32'hF900_0050, 32'h0,          32'h7777_7777, 20, 2'd0, 0, 2'd2, 19, 32'h3333_4444};
        vt[5] = '{1'b0, 32'hF900_0060, 32'h0,          32'h5555_AAAA, 14, 2'd0, 0, 2'd0, 19, 32'h5555_AAAA};
        vt[6] = '{1'b1, 32'hF900_0070, 32'hA5A5_0F0F,  32'h0,         13, 2'd2, 0, 2'd2, 18, 32'h5555_AAAA};
        vt[7] = '{1'b0, 32'hF900_0080, 32'h0,          32'h0102_0304, 0,  2'd0, 6, 2'd0, 10, 32'h0102_0304};

        rst = 1'b1;
        comp_arb = 4'hF;
        bus.host_valid = 1'b0; bus.host_write = 1'b0;
        bus.host_addr = 32'h0; bus.host_wdata = 32'h0;
        bus.nub_adn_i = 32'hFFFF_FFFF; bus.nub_startn_i = 1'b1; bus.nub_ackn_i = 1'b1;
        bus.nub_rqstn_i = 1'b1; bus.nub_tm1n_i = 1'b1; bus.nub_tm0n_i = 1'b1;
        repeat (2) @(negedge clk);
        chk_released("reset");
        chk("reset_ready",  {31'd0, bus.host_ready}, 32'd0);
        chk("reset_rdata",  bus.host_rdata, 32'd0);
        chk("reset_status", {30'd0, bus.host_status}, 32'd0);
        chk("reset_adn_o",  bus.nub_adn_o, 32'hFFFF_FFFF);
        chk("reset_startn_o", {31'd0, bus.nub_startn_o}, 32'd1);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) run_txn(vt[k], 1'b0);

        // A request strobe seen during DONE must not start another transfer.
        r = '{1'b0, 32'hF900_0090, 32'h0, 32'hCAFE_F00D, 0, 2'd0, 0, 2'd0, 5, 32'hCAFE_F00D};
        run_txn(r, 1'b1);

        // Reset while a write is in DATA: bus released at once, no completion.
        @(negedge clk);
        bus.host_write = 1'b1; bus.host_addr = 32'hF900_00A0; bus.host_wdata = 32'h600D_F00D;
        bus.host_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            bus.host_valid = 1'b0;
        end
        chk("pre_reset_adn_oe", {31'd0, bus.nub_adn_oe}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_released("midreset");
        chk("midreset_rdata",  bus.host_rdata, 32'd0);
        chk("midreset_status", {30'd0, bus.host_status}, 32'd0);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("no_ready_after_reset", {31'd0, bus.host_ready}, 32'd0);
        end
        r = '{1'b0, 32'hF900_00B0, 32'h0, 32'h0F0F_1234, 1, 2'd0, 0, 2'd0, 6, 32'h0F0F_1234};
        run_txn(r, 1'b0);
        prev_rd = 32'h0F0F_1234;

        for (int k = 0; k < 40; k++) begin
            r.wr    = 1'($urandom_range(0, 1));
            r.addr  = $urandom;
            r.wdata = $urandom;
            r.resp  = $urandom;
            r.waits = $urandom_range(0, 17);
            r.code  = 2'($urandom_range(0, 3));
            r.hold  = $urandom_range(0, 4);
            acked   = (r.waits < DATA_MAX);
            dc      = acked ? r.waits + 1 : DATA_MAX;
            r.exp_lat = ((r.hold <= 1) ? 3 : r.hold + 2) + dc + 1;
            r.exp_st  = acked ? r.code : 2'd2;
            r.exp_rd  = (acked && !r.wr) ? r.resp : prev_rd;
            prev_rd   = r.exp_rd;
            run_txn(r, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
